// File: rtl/hazard_stall_ctrl_if.sv
// Decode/execute/memory hazard inputs and stall/MDU control outputs
// shared between the pipeline and hazard_stall_ctrl.
interface hazard_stall_ctrl_if;
  logic [4:0]  i_addr_Drs;
  logic [4:0]  i_addr_Drt;
  logic        i_con_Duse_rs;
  logic        i_con_Duse_rt;
  logic        i_con_Dbrcmp;
  logic        i_con_Dmdu_start;
  logic        i_con_Dmdu_div;
  logic        i_con_Dmdu_read;
  logic [4:0]  i_addr_Ewrite;
  logic        i_con_Eregwrite;
  logic        i_con_Ememread;
  logic [4:0]  i_addr_Mwrite;
  logic        i_con_Mregwrite;
  logic        i_con_Mmemread;
  logic        o_con_stallF;
  logic        o_con_stallD;
  logic        o_con_flushE;
  logic        o_con_mdu_start;
  logic        o_con_mdu_busy;
  logic        o_con_mdu_done;
  logic [31:0] o_cnt_stall;
  logic [31:0] o_cnt_mdu_stall;

  modport master (
    output i_addr_Drs, i_addr_Drt,
    output i_con_Duse_rs, i_con_Duse_rt,
    output i_con_Dbrcmp,
    output i_con_Dmdu_start, i_con_Dmdu_div,
    output i_con_Dmdu_read,
    output i_addr_Ewrite, i_con_Eregwrite,
    output i_con_Ememread,
    output i_addr_Mwrite, i_con_Mregwrite,
    output i_con_Mmemread,
    input  o_con_stallF, o_con_stallD,
    input  o_con_flushE,
    input  o_con_mdu_start, o_con_mdu_busy,
    input  o_con_mdu_done,
    input  o_cnt_stall, o_cnt_mdu_stall
  );

  modport slave (
    input  i_addr_Drs, i_addr_Drt,
    input  i_con_Duse_rs, i_con_Duse_rt,
    input  i_con_Dbrcmp,
    input  i_con_Dmdu_start, i_con_Dmdu_div,
    input  i_con_Dmdu_read,
    input  i_addr_Ewrite, i_con_Eregwrite,
    input  i_con_Ememread,
    input  i_addr_Mwrite, i_con_Mregwrite,
    input  i_con_Mmemread,
    output o_con_stallF, o_con_stallD,
    output o_con_flushE,
    output o_con_mdu_start, o_con_mdu_busy,
    output o_con_mdu_done,
    output o_cnt_stall, o_cnt_mdu_stall
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard stall and MDU busy/done sequencer.
// HAZARD_PERF_EN builds saturating stall performance counters.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input logic               i_clk,
  input logic               i_rst,
  hazard_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } mdu_state_e;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

  mdu_state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  logic e_hit, m_hit;
  logic lu_haz, br_haz, mdu_haz;
  logic stall, accept;

  always_comb begin
    e_hit = (bus.i_con_Duse_rs
             && bus.i_con_Eregwrite
             && bus.i_addr_Drs == bus.i_addr_Ewrite
             && bus.i_addr_Drs != 5'd0)
         || (bus.i_con_Duse_rt
             && bus.i_con_Eregwrite
             && bus.i_addr_Drt == bus.i_addr_Ewrite
             && bus.i_addr_Drt != 5'd0);
    m_hit = (bus.i_con_Duse_rs
             && bus.i_con_Mregwrite
             && bus.i_addr_Drs == bus.i_addr_Mwrite
             && bus.i_addr_Drs != 5'd0)
         || (bus.i_con_Duse_rt
             && bus.i_con_Mregwrite
             && bus.i_addr_Drt == bus.i_addr_Mwrite
             && bus.i_addr_Drt != 5'd0);
  end

  assign lu_haz  = e_hit & bus.i_con_Ememread;
  assign br_haz  = bus.i_con_Dbrcmp
                 & (e_hit | (m_hit & bus.i_con_Mmemread));
  assign mdu_haz = (bus.i_con_Dmdu_read | bus.i_con_Dmdu_start)
                 & (state_q != S_IDLE);
  // Outputs read 0 while reset is held.
  assign stall   = ~i_rst & (lu_haz | br_haz | mdu_haz);
  assign accept  = ~i_rst & bus.i_con_Dmdu_start & ~stall;

  assign bus.o_con_stallF    = stall;
  assign bus.o_con_stallD    = stall;
  assign bus.o_con_flushE    = stall;
  assign bus.o_con_mdu_start = accept;
  assign bus.o_con_mdu_busy  = (state_q != S_IDLE);
  assign bus.o_con_mdu_done  = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BUSY;
          cnt_d   = bus.i_con_Dmdu_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      S_BUSY: begin
        if (cnt_q == 6'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] cnt_stall_q, cnt_stall_d;
  logic [31:0] cnt_mdu_q, cnt_mdu_d;

  always_comb begin
    cnt_stall_d = cnt_stall_q;
    cnt_mdu_d   = cnt_mdu_q;
    if (stall && cnt_stall_q != 32'hFFFF_FFFF) begin
      cnt_stall_d = cnt_stall_q + 32'd1;
    end
    if (mdu_haz && cnt_mdu_q != 32'hFFFF_FFFF) begin
      cnt_mdu_d = cnt_mdu_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_stall_q <= 32'd0;
      cnt_mdu_q   <= 32'd0;
    end else begin
      cnt_stall_q <= cnt_stall_d;
      cnt_mdu_q   <= cnt_mdu_d;
    end
  end

  assign bus.o_cnt_stall     = cnt_stall_q;
  assign bus.o_cnt_mdu_stall = cnt_mdu_q;
`else
  assign bus.o_cnt_stall     = 32'd0;
  assign bus.o_cnt_mdu_stall = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: load-use, branch,
// MDU sequencing, reset mid-operation and perf counters.
module tb_hazard_stall_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic i_clk;
  logic i_rst;
  int   checks;
  int   errors;
  int   exp_stall;
  int   exp_mdu;

  hazard_stall_ctrl_if hif ();

  hazard_stall_ctrl #(
    .MULT_CYCLES(4),
    .DIV_CYCLES (32)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (hif.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr();
    hif.i_addr_Drs       = 5'd0;
    hif.i_addr_Drt       = 5'd0;
    hif.i_con_Duse_rs    = 1'b0;
    hif.i_con_Duse_rt    = 1'b0;
    hif.i_con_Dbrcmp     = 1'b0;
    hif.i_con_Dmdu_start = 1'b0;
    hif.i_con_Dmdu_div   = 1'b0;
    hif.i_con_Dmdu_read  = 1'b0;
    hif.i_addr_Ewrite    = 5'd0;
    hif.i_con_Eregwrite  = 1'b0;
    hif.i_con_Ememread   = 1'b0;
    hif.i_addr_Mwrite    = 5'd0;
    hif.i_con_Mregwrite  = 1'b0;
    hif.i_con_Mmemread   = 1'b0;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_stall(input string tag,
                           input logic exp);
    chk({tag, "_stallF"}, {31'd0, hif.o_con_stallF}, {31'd0, exp});
    chk({tag, "_stallD"}, {31'd0, hif.o_con_stallD}, {31'd0, exp});
    chk({tag, "_flushE"}, {31'd0, hif.o_con_flushE}, {31'd0, exp});
  endtask

  task automatic chk_perf(input string tag);
    chk({tag, "_cnt_stall"}, hif.o_cnt_stall,
        PERF ? 32'(exp_stall) : 32'd0);
    chk({tag, "_cnt_mdu"}, hif.o_cnt_mdu_stall,
        PERF ? 32'(exp_mdu) : 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_stall = 0;
    exp_mdu   = 0;
    clr();
    i_rst = 1'b1;

    // reset state
    step();
    step();
    chk_stall("rst", 1'b0);
    chk("rst_start", {31'd0, hif.o_con_mdu_start}, 0);
    chk("rst_busy", {31'd0, hif.o_con_mdu_busy}, 0);
    chk("rst_done", {31'd0, hif.o_con_mdu_done}, 0);
    chk_perf("rst");
    i_rst = 1'b0;

    // load-use: lw $2 in E, add rs=2 in decode
    step();
    clr();
    hif.i_addr_Ewrite   = 5'd2;
    hif.i_con_Eregwrite = 1'b1;
    hif.i_con_Ememread  = 1'b1;
    hif.i_addr_Drs      = 5'd2;
    hif.i_con_Duse_rs   = 1'b1;
    #1;
    chk_stall("lu", 1'b1);
    exp_stall++;
    step();
    clr();
    hif.i_addr_Mwrite   = 5'd2;
    hif.i_con_Mregwrite = 1'b1;
    hif.i_con_Mmemread  = 1'b1;
    hif.i_addr_Drs      = 5'd2;
    hif.i_con_Duse_rs   = 1'b1;
    #1;
    chk_stall("lu_adv", 1'b0);

    // register 0 never matches
    step();
    clr();
    hif.i_addr_Ewrite   = 5'd0;
    hif.i_con_Eregwrite = 1'b1;
    hif.i_con_Ememread  = 1'b1;
    hif.i_addr_Drs      = 5'd0;
    hif.i_con_Duse_rs   = 1'b1;
    #1;
    chk_stall("lu_r0", 1'b0);

    // rt match without regwrite
    step();
    clr();
    hif.i_addr_Ewrite   = 5'd9;
    hif.i_con_Ememread  = 1'b1;
    hif.i_addr_Drt      = 5'd9;
    hif.i_con_Duse_rt   = 1'b1;
    #1;
    chk_stall("lu_nowr", 1'b0);
    hif.i_con_Eregwrite = 1'b1;
    #1;
    chk_stall("lu_rt", 1'b1);
    exp_stall++;

    // lw $5 then beq $5,$0: two stall cycles
    step();
    clr();
    hif.i_addr_Ewrite   = 5'd5;
    hif.i_con_Eregwrite = 1'b1;
    hif.i_con_Ememread  = 1'b1;
    hif.i_addr_Drs      = 5'd5;
    hif.i_con_Duse_rs   = 1'b1;
    hif.i_con_Duse_rt   = 1'b1;
    hif.i_con_Dbrcmp    = 1'b1;
    #1;
    chk_stall("br_ld_e", 1'b1);
    exp_stall++;
    step();
    clr();
    hif.i_addr_Mwrite   = 5'd5;
    hif.i_con_Mregwrite = 1'b1;
    hif.i_con_Mmemread  = 1'b1;
    hif.i_addr_Drs      = 5'd5;
    hif.i_con_Duse_rs   = 1'b1;
    hif.i_con_Duse_rt   = 1'b1;
    hif.i_con_Dbrcmp    = 1'b1;
    #1;
    chk_stall("br_ld_m", 1'b1);
    exp_stall++;
    step();
    clr();
    hif.i_addr_Drs      = 5'd5;
    hif.i_con_Duse_rs   = 1'b1;
    hif.i_con_Dbrcmp    = 1'b1;
    #1;
    chk_stall("br_ld_go", 1'b0);

    // branch on ALU result: one stall cycle
    step();
    clr();
    hif.i_addr_Ewrite   = 5'd7;
    hif.i_con_Eregwrite = 1'b1;
    hif.i_addr_Drt      = 5'd7;
    hif.i_con_Duse_rt   = 1'b1;
    hif.i_con_Dbrcmp    = 1'b1;
    #1;
    chk_stall("br_alu_e", 1'b1);
    exp_stall++;
    step();
    clr();
    hif.i_addr_Mwrite   = 5'd7;
    hif.i_con_Mregwrite = 1'b1;
    hif.i_addr_Drt      = 5'd7;
    hif.i_con_Duse_rt   = 1'b1;
    hif.i_con_Dbrcmp    = 1'b1;
    #1;
    chk_stall("br_alu_m", 1'b0);
    chk_perf("hazards");

    // mult then mflo held from cycle 1
    step();
    clr();
    hif.i_con_Dmdu_start = 1'b1;
    #1;
    chk("mul_start", {31'd0, hif.o_con_mdu_start}, 1);
    chk_stall("mul_c0", 1'b0);
    for (int c = 1; c <= 6; c++) begin
      step();
      clr();
      hif.i_con_Dmdu_read = 1'b1;
      #1;
      chk_stall("mflo", c <= 5);
      chk("mul_busy", {31'd0, hif.o_con_mdu_busy},
          (c <= 5) ? 1 : 0);
      chk("mul_done", {31'd0, hif.o_con_mdu_done},
          (c == 5) ? 1 : 0);
      if (c <= 5) begin
        exp_stall++;
        exp_mdu++;
      end
    end
    chk_perf("mflo");

    // div followed by a waiting mult
    step();
    clr();
    hif.i_con_Dmdu_start = 1'b1;
    hif.i_con_Dmdu_div   = 1'b1;
    #1;
    chk("div_start", {31'd0, hif.o_con_mdu_start}, 1);
    for (int c = 1; c <= 33; c++) begin
      step();
      clr();
      hif.i_con_Dmdu_start = 1'b1;
      #1;
      chk("div_hold_start", {31'd0, hif.o_con_mdu_start}, 0);
      chk("div_hold_stall", {31'd0, hif.o_con_stallD}, 1);
      chk("div_done", {31'd0, hif.o_con_mdu_done},
          (c == 33) ? 1 : 0);
      exp_stall++;
      exp_mdu++;
    end
    step();
    clr();
    hif.i_con_Dmdu_start = 1'b1;
    #1;
    chk("mul2_start", {31'd0, hif.o_con_mdu_start}, 1);
    chk("mul2_idle", {31'd0, hif.o_con_mdu_busy}, 0);
    chk_stall("mul2_c34", 1'b0);
    for (int c = 35; c <= 40; c++) begin
      step();
      clr();
      #1;
      chk("mul2_busy", {31'd0, hif.o_con_mdu_busy},
          (c <= 39) ? 1 : 0);
      chk("mul2_done", {31'd0, hif.o_con_mdu_done},
          (c == 39) ? 1 : 0);
    end
    chk_perf("div_mul");

    // reset while BUSY with cnt = 10 (div cycle 22)
    step();
    clr();
    hif.i_con_Dmdu_start = 1'b1;
    hif.i_con_Dmdu_div   = 1'b1;
    #1;
    chk("rdiv_start", {31'd0, hif.o_con_mdu_start}, 1);
    for (int c = 1; c <= 22; c++) begin
      step();
      clr();
      #1;
      chk("rdiv_busy", {31'd0, hif.o_con_mdu_busy}, 1);
    end
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    exp_stall = 0;
    exp_mdu   = 0;
    #1;
    chk("rst_mid_busy", {31'd0, hif.o_con_mdu_busy}, 0);
    chk_perf("rst_mid");
    for (int c = 0; c < 12; c++) begin
      step();
      #1;
      chk("rst_mid_done", {31'd0, hif.o_con_mdu_done}, 0);
      chk("rst_mid_idle", {31'd0, hif.o_con_mdu_busy}, 0);
    end

    // MDU start coincident with load-use
    step();
    clr();
    hif.i_addr_Ewrite    = 5'd2;
    hif.i_con_Eregwrite  = 1'b1;
    hif.i_con_Ememread   = 1'b1;
    hif.i_addr_Drs       = 5'd2;
    hif.i_con_Duse_rs    = 1'b1;
    hif.i_con_Dmdu_start = 1'b1;
    #1;
    chk("co_start", {31'd0, hif.o_con_mdu_start}, 0);
    chk_stall("co_stall", 1'b1);
    exp_stall++;
    step();
    clr();
    hif.i_addr_Mwrite    = 5'd2;
    hif.i_con_Mregwrite  = 1'b1;
    hif.i_con_Mmemread   = 1'b1;
    hif.i_addr_Drs       = 5'd2;
    hif.i_con_Duse_rs    = 1'b1;
    hif.i_con_Dmdu_start = 1'b1;
    #1;
    chk("co_start2", {31'd0, hif.o_con_mdu_start}, 1);
    chk_stall("co_go", 1'b0);
    step();
    clr();
    #1;
    chk("co_busy", {31'd0, hif.o_con_mdu_busy}, 1);
    chk_perf("co");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and multi-cycle scheduler for the decode stage of the 5-stage MIPS core. It decides every cycle whether the instruction in decode may advance. It stalls fetch/decode and injects a bubble into the decode/execute pipe register on load-use and branch-operand hazards. It also sequences the multiply/divide unit (MDU) through a busy/done state machine, so HI/LO readers and new MDU ops wait for completion.

## Interface
Parameters:
- MULT_CYCLES, 4, MDU cycles for mult/multu (1..63)
- DIV_CYCLES, 32, MDU cycles for div/divu (1..63)

Ports:
- i_clk  in  1  clock; single clock domain
- i_rst  in  1  reset, synchronous, active-high
- i_addr_Drs, i_addr_Drt  in  5 each  decode source register numbers (instr[25:21], instr[20:16])
- i_con_Duse_rs, i_con_Duse_rt  in  1 each  decode instruction reads rs / rt
- i_con_Dbrcmp  in  1  decode instruction compares registers in decode (beq/bne/bltz/jr/jalr)
- i_con_Dmdu_start  in  1  decode holds mult/multu/div/divu
- i_con_Dmdu_div  in  1  with start: op is a divide
- i_con_Dmdu_read  in  1  decode holds mfhi/mflo
- i_addr_Ewrite, i_con_Eregwrite, i_con_Ememread  in  5,1,1  execute-stage destination, write enable, load flag
- i_addr_Mwrite, i_con_Mregwrite, i_con_Mmemread  in  5,1,1  memory-stage destination, write enable, load flag
- o_con_stallF  out  1  hold PC
- o_con_stallD  out  1  hold fetch/decode register
- o_con_flushE  out  1  load bubble (all controls 0) into decode/execute register
- o_con_mdu_start  out  1  accepted MDU start pulse to the MDU datapath
- o_con_mdu_busy  out  1  MDU state is not IDLE
- o_con_mdu_done  out  1  one-cycle HI/LO write enable
- o_cnt_stall  out  32  cycles with stall asserted (perf)
- o_cnt_mdu_stall  out  32  stall cycles caused by the MDU (perf)

## Operation
- A source matches a stage when its use flag = 1, its address equals the stage destination, that stage's regwrite = 1, and the address is nonzero. Register 0 never matches.
- lu_haz: E matches, with i_con_Ememread = 1.
- br_haz: i_con_Dbrcmp = 1 and either E matches, or M matches with i_con_Mmemread = 1.
- mdu_haz: (i_con_Dmdu_read or i_con_Dmdu_start) and state != IDLE.
- stall = lu_haz | br_haz | mdu_haz. When stall = 1, o_con_stallF, o_con_stallD and o_con_flushE are all 1; otherwise all 0.
- Accept: o_con_mdu_start = i_con_Dmdu_start & ~stall.
- MDU FSM states and transitions:
  - IDLE: on accept, go to BUSY and load cnt = (div ? DIV_CYCLES : MULT_CYCLES) - 1.
  - BUSY: if cnt == 0, go to DONE; else cnt decrements.
  - DONE: o_con_mdu_done = 1; go to IDLE.
- cnt is 6 bits wide and never underflows.
- o_con_mdu_busy = (state != IDLE). It is therefore 1 in DONE, so an mfhi/mflo issued in the DONE cycle stalls one more cycle.
- Reset values (all outputs): every output is 0, state = IDLE, cnt = 0, perf counters = 0.
- Reset mid-operation: the FSM returns to IDLE with no done pulse. The MDU result is discarded.

## Timing
- stall, flushE and mdu_start are combinational from the inputs and the registered state, all in the same cycle.
- mdu_start is 1 in cycle 0; BUSY spans cycles 1..N; o_con_mdu_done = 1 in cycle N+1; IDLE from cycle N+2. N = MULT_CYCLES or DIV_CYCLES.
- A load-use hazard stalls exactly 1 cycle, because the load moves to M on the next edge.
- A branch that depends on a load costs 2 cycles:
  - cycle 1: the load is in E;
  - cycle 2: the load is in M with memread = 1.
- A branch that depends on an ALU result in E costs 1 cycle, because the M-stage ALU result is forwarded elsewhere.
- Simultaneous hazards OR together. There is no priority and the stall is not double-counted.

## Configuration
- HAZARD_PERF_EN defined:
  - o_cnt_stall increments on every cycle with stall = 1.
  - o_cnt_mdu_stall increments on every cycle with mdu_haz = 1.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- HAZARD_PERF_EN undefined: both counters are tied to 0 and no counter flops are built. The ports remain present.

## Test plan
- lw $2 in E (Ememread = 1, Ewrite = 2), add using rs = 2 in decode -> stallF/stallD/flushE = 1 for 1 cycle. Same case with Ewrite = 0 -> no stall.
- lw $5 then beq $5,$0 -> stall = 1 for 2 consecutive cycles (E then M), 0 on the 3rd.
- mult accepted with MULT_CYCLES = 4 -> mdu_start in cycle 0, busy in cycles 1-5, done = 1 in cycle 5 only. An mflo held in decode from cycle 1 stalls cycles 1-5 and advances in cycle 6; o_cnt_mdu_stall = 5.
- div (DIV_CYCLES = 32) followed by a mult in decode -> mult stalls until IDLE, is accepted 34 cycles after the div start, and then runs 4 cycles.
- Assert i_rst at BUSY cnt = 10 -> next cycle busy = 0, done never pulses, perf counters = 0.
- MDU start coincident with a load-use hazard -> mdu_start = 0 that cycle; the start is accepted the following cycle.
